// File: rtl/inverse_rotation_engine_if.sv
// Vertex payload type and the handshake bundle between a vertex source/sink and the inverse rotation engine.
package graphics_type_pkg;
    localparam int unsigned COORD_W = 10;
    localparam int unsigned ANGLE_W = 16;

    typedef struct packed {
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
        logic signed [COORD_W-1:0] z;
    } vertex_3d_t;
endpackage

interface inverse_rotation_engine_if;
    import graphics_type_pkg::*;

    logic                      in_valid;
    logic                      in_ready;
    vertex_3d_t                v_in;
    logic signed [ANGLE_W-1:0] angle_x;
    logic signed [ANGLE_W-1:0] angle_y;
    logic signed [ANGLE_W-1:0] angle_z;
    logic                      out_valid;
    logic                      out_ready;
    vertex_3d_t                v_out;
    logic                      busy;

    modport master (
        output in_valid, v_in, angle_x, angle_y, angle_z, out_ready,
        input  in_ready, out_valid, v_out, busy
    );

    modport slave (
        input  in_valid, v_in, angle_x, angle_y, angle_z, out_ready,
        output in_ready, out_valid, v_out, busy
    );
endinterface

// File: rtl/inverse_rotation_engine.sv
// Undoes a forward X->Y->Z rotation by rotating Z, Y, X with negated angles,
// one axis per cycle through a single shared 4-multiplier plane rotator.
module inverse_rotation_engine
    import graphics_type_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    inverse_rotation_engine_if.slave bus
);

    localparam int unsigned ANG_W  = 8;
    localparam int unsigned PROD_W = 32;
    localparam int unsigned FRAC_W = 8;

    typedef enum logic [2:0] {IDLE, ROT_Z, ROT_Y, ROT_X, DONE} state_e;

    state_e             state_q, state_d;
    vertex_3d_t         work_q, work_d;
    logic [ANG_W-1:0]   ang_x_q, ang_x_d;
    logic [ANG_W-1:0]   ang_y_q, ang_y_d;
    logic [ANG_W-1:0]   ang_z_q, ang_z_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic               in_ready_c;
    logic               hs_c;

    logic signed [COORD_W-1:0] p_c, q_c, p_new_c, q_new_c;
    logic signed [COORD_W-1:0] cos_c, sin_c;
    logic        [ANG_W-1:0]   ang_c;
    logic signed [PROD_W-1:0]  p32_c, q32_c, c32_c, s32_c;

    // Upper angle bits carry no information at 256 units per turn.
    logic unused_angle_bits;
    assign unused_angle_bits = ^{bus.angle_x[ANGLE_W-1:ANG_W],
                                 bus.angle_y[ANGLE_W-1:ANG_W],
                                 bus.angle_z[ANGLE_W-1:ANG_W]};

    function automatic logic signed [COORD_W-1:0] cos_lut(input logic [3:0] idx);
        case (idx)
            4'd0:    cos_lut =  10'sd256;
            4'd1:    cos_lut =  10'sd236;
            4'd2:    cos_lut =  10'sd181;
            4'd3:    cos_lut =  10'sd98;
            4'd4:    cos_lut =  10'sd0;
            4'd5:    cos_lut = -10'sd98;
            4'd6:    cos_lut = -10'sd181;
            4'd7:    cos_lut = -10'sd236;
            4'd8:    cos_lut = -10'sd256;
            4'd9:    cos_lut = -10'sd236;
            4'd10:   cos_lut = -10'sd181;
            4'd11:   cos_lut = -10'sd98;
            4'd12:   cos_lut =  10'sd0;
            4'd13:   cos_lut =  10'sd98;
            4'd14:   cos_lut =  10'sd181;
            default: cos_lut =  10'sd236;
        endcase
    endfunction

    assign in_ready_c = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign hs_c       = bus.in_valid && in_ready_c;

    // Every axis is the plane rotation p' = p*c - q*s, q' = p*s + q*c on a chosen coordinate pair.
    always_comb begin
        p_c   = work_q.y;
        q_c   = work_q.z;
        ang_c = ang_x_q;
        case (state_q)
            ROT_Z: begin p_c = work_q.x; q_c = work_q.y; ang_c = ang_z_q; end
            ROT_Y: begin p_c = work_q.z; q_c = work_q.x; ang_c = ang_y_q; end
            default: ;
        endcase
        cos_c   = cos_lut(ang_c[7:4]);
        sin_c   = cos_lut(ang_c[7:4] - 4'd4);
        p32_c   = p_c;
        q32_c   = q_c;
        c32_c   = cos_c;
        s32_c   = sin_c;
        p_new_c = COORD_W'((p32_c * c32_c - q32_c * s32_c) >>> FRAC_W);
        q_new_c = COORD_W'((p32_c * s32_c + q32_c * c32_c) >>> FRAC_W);
    end

    // Next-state and working-register update.
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        ang_x_d     = ang_x_q;
        ang_y_d     = ang_y_q;
        ang_z_d     = ang_z_q;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;

        case (state_q)
            IDLE: if (hs_c) state_d = ROT_Z;
            ROT_Z: begin
                work_d.x = p_new_c;
                work_d.y = q_new_c;
                state_d  = ROT_Y;
            end
            ROT_Y: begin
                work_d.z = p_new_c;
                work_d.x = q_new_c;
                state_d  = ROT_X;
            end
            ROT_X: begin
                work_d.y = p_new_c;
                work_d.z = q_new_c;
                state_d  = DONE;
            end
            DONE: begin
                if (hs_c)               state_d = ROT_Z;
                else if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (hs_c) begin
            work_d  = bus.v_in;
            ang_x_d = ANG_W'(8'd0 - bus.angle_x[ANG_W-1:0]);
            ang_y_d = ANG_W'(8'd0 - bus.angle_y[ANG_W-1:0]);
            ang_z_d = ANG_W'(8'd0 - bus.angle_z[ANG_W-1:0]);
        end

        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            work_q      <= '0;
            ang_x_q     <= '0;
            ang_y_q     <= '0;
            ang_z_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            ang_x_q     <= ang_x_d;
            ang_y_q     <= ang_y_d;
            ang_z_q     <= ang_z_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.v_out     = work_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_inverse_rotation_engine.sv
// Self-checking bench for inverse_rotation_engine: directed corner cases plus random vertices
// against a plain-integer model of the Z->Y->X inverse rotation.
module tb_inverse_rotation_engine;
    import graphics_type_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    inverse_rotation_engine_if bus();

    inverse_rotation_engine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cos_tab [16] = '{256, 236, 181, 98, 0, -98, -181, -236,
                         -256, -236, -181, -98, 0, 98, 181, 236};

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int cosf(input int a);
        return cos_tab[(a & 255) >> 4];
    endfunction

    function automatic int sinf(input int a);
        return cosf(a - 64);
    endfunction

    function automatic int wrap10(input int v);
        return ((v + 512) & 1023) - 512;
    endfunction

    // Inverse of a forward X, Y, Z rotation: Z, Y, X each with the negated angle.
    task automatic ref_rot(input int x, y, z, ax, ay, az, output int ox, oy, oz);
        int a, c, s, nx, ny, nz;
        a = (-az) & 255; c = cosf(a); s = sinf(a);
        nx = wrap10((x * c - y * s) >>> 8);
        ny = wrap10((x * s + y * c) >>> 8);
        x = nx; y = ny;
        a = (-ay) & 255; c = cosf(a); s = sinf(a);
        nx = wrap10((x * c + z * s) >>> 8);
        nz = wrap10((-x * s + z * c) >>> 8);
        x = nx; z = nz;
        a = (-ax) & 255; c = cosf(a); s = sinf(a);
        ny = wrap10((y * c - z * s) >>> 8);
        nz = wrap10((y * s + z * c) >>> 8);
        ox = x; oy = ny; oz = nz;
    endtask

    task automatic drive(input int x, y, z, ax, ay, az);
        bus.v_in.x  = 10'(x);
        bus.v_in.y  = 10'(y);
        bus.v_in.z  = 10'(z);
        bus.angle_x = 16'(ax);
        bus.angle_y = 16'(ay);
        bus.angle_z = 16'(az);
    endtask

    function automatic int ox_f(); return int'(bus.v_out.x); endfunction
    function automatic int oy_f(); return int'(bus.v_out.y); endfunction
    function automatic int oz_f(); return int'(bus.v_out.z); endfunction

    task automatic run_one(input string tag, input int x, y, z, ax, ay, az);
        int ex, ey, ez, lat;
        ref_rot(x, y, z, ax, ay, az, ex, ey, ez);
        @(negedge clk);
        drive(x, y, z, ax, ay, az);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1 check({tag, "_in_ready"}, int'(bus.in_ready), 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        check({tag, "_latency"}, lat, 3);
        check({tag, "_x"}, ox_f(), ex);
        check({tag, "_y"}, oy_f(), ey);
        check({tag, "_z"}, oz_f(), ez);
        @(posedge clk);
        #1 check({tag, "_idle"}, int'(bus.busy), 0);
    endtask

    initial begin
        int ex, ey, ez, lat, k, cyc, nout, last_cyc;
        int bx [3], by [3], bz [3], ba [3];
        int qx [3], qy [3], qz [3];
        bit take;

        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_v_out", int'(bus.v_out), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_in_ready", int'(bus.in_ready), 1);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;

        run_one("identity", 100, -50, 25, 0, 0, 0);
        run_one("rotz64", 100, 0, 0, 0, 0, 64);
        run_one("rotx128", 10, 20, 30, 128, 0, 0);
        run_one("wrap", 400, 400, 0, 0, 0, 32);
        check("wrap_const_x", -459, wrap10(565));

        for (int i = 0; i < 25; i++)
            run_one($sformatf("rand%0d", i),
                    int'($urandom_range(1023)) - 512, int'($urandom_range(1023)) - 512,
                    int'($urandom_range(1023)) - 512, int'($urandom_range(65535)),
                    int'($urandom_range(65535)), int'($urandom_range(65535)));

        // Backpressure: vertex A held in DONE while vertex B waits.
        ref_rot(123, -77, 300, 40, 90, 200, ex, ey, ez);
        @(negedge clk);
        drive(123, -77, 300, 40, 90, 200);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        check("bp_latency", lat, 3);
        @(negedge clk);
        drive(-200, 50, 7, 16, 32, 48);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_in_ready", int'(bus.in_ready), 0);
            check("bp_out_valid", int'(bus.out_valid), 1);
            check("bp_hold_x", ox_f(), ex);
            check("bp_hold_y", oy_f(), ey);
            check("bp_hold_z", oz_f(), ez);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1 check("bp_release_in_ready", int'(bus.in_ready), 1);
        ref_rot(-200, 50, 7, 16, 32, 48, ex, ey, ez);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        check("bp_accept_busy", int'(bus.busy), 1);
        check("bp_accept_out_valid", int'(bus.out_valid), 0);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        check("bp_b_latency", lat, 3);
        check("bp_b_x", ox_f(), ex);
        check("bp_b_y", oy_f(), ey);
        check("bp_b_z", oz_f(), ez);
        @(posedge clk);

        // Reset during ROT_Y aborts the vertex with no output.
        @(negedge clk);
        drive(250, 250, 250, 10, 20, 30);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(bus.out_valid), 0);
        check("midrst_v_out", int'(bus.v_out), 0);
        check("midrst_busy", int'(bus.busy), 0);
        @(negedge clk) rst_n = 1'b1;
        #1 check("midrst_in_ready", int'(bus.in_ready), 1);
        nout = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) nout++;
        end
        check("midrst_no_stale", nout, 0);

        // Back-to-back vertices with the output always accepted.
        for (int i = 0; i < 3; i++) begin
            bx[i] = int'($urandom_range(1023)) - 512;
            by[i] = int'($urandom_range(1023)) - 512;
            bz[i] = int'($urandom_range(1023)) - 512;
            ba[i] = int'($urandom_range(255));
            ref_rot(bx[i], by[i], bz[i], ba[i], 255 - ba[i], ba[i] ^ 85, qx[i], qy[i], qz[i]);
        end
        bus.out_ready = 1'b1;
        k = 0; cyc = 0; nout = 0; last_cyc = 0;
        while ((k < 3 || nout < 3) && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.out_valid && nout < 3) begin
                check($sformatf("b2b%0d_x", nout), ox_f(), qx[nout]);
                check($sformatf("b2b%0d_y", nout), oy_f(), qy[nout]);
                check($sformatf("b2b%0d_z", nout), oz_f(), qz[nout]);
                if (nout > 0) check($sformatf("b2b%0d_gap", nout), cyc - last_cyc, 4);
                last_cyc = cyc;
                nout++;
            end
            if (k < 3) begin
                drive(bx[k], by[k], bz[k], ba[k], 255 - ba[k], ba[k] ^ 85);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1 take = bus.in_valid && bus.in_ready;
            @(posedge clk);
            if (take) k++;
        end
        check("b2b_count", nout, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
